// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite-DMA controller and the CPU/IO address decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package oam_dma_ctrl_pkg;

    // DMA controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    // CPU-visible I/O register addresses (sprite DMA register first)
    localparam logic [15:0] IO_OAMDMA = 16'h4014;

    // Source byte address inside the selected page; the page byte never takes a carry
    function automatic logic [15:0] dma_mem_addr(input logic [7:0] page, input logic [7:0] idx);
        return {page, idx};
    endfunction

endpackage

// File: rtl/nes_bus_mux.sv
// Selects whether the CPU or the DMA engine drives the RAM bus.
// Latency: purely combinational.
// Backpressure: none; the DMA side always owns the bus while selected, CPU is held upstream.
module nes_bus_mux (
    input  logic        dma_sel,
    input  logic        trig_block,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw_n,
    input  logic        cpu_cs_n,
    input  logic [15:0] dma_addr,
    input  logic        dma_cs_n,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw_n,
    output logic        mem_cs_n
);

    // DMA owns the bus outside IDLE (read-only); otherwise CPU passes through,
    // with the DMA-register write itself kept off the RAM chip select
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rw_n  = cpu_rw_n;
        mem_cs_n  = cpu_cs_n | trig_block;
        if (dma_sel) begin
            mem_addr  = dma_addr;
            mem_wdata = 8'h00;
            mem_rw_n  = 1'b1;
            mem_cs_n  = dma_cs_n;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller: passes CPU cycles to RAM, and on a DMA-register write copies one page into OAM.
// Latency: trigger -> CPU held next cycle; stall is 513 cycles (514 when HALT lands on an odd cycle).
// Backpressure: CPU is stalled via cpu_rdy=0 for the whole transfer; CPU bus inputs are ignored meanwhile.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = IO_OAMDMA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw_n,
    input  logic        cpu_cs_n,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw_n,
    output logic        mem_cs_n,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_busy
);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic       odd_q;
    logic       trigger;
    logic       dma_cs_n;

    // State, transfer registers and the free-running cycle-parity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            odd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            odd_q   <= ~odd_q;
        end
    end

    // Next-state, transfer bookkeeping and OAM write strobe
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        trigger   = 1'b0;
        dma_cs_n  = 1'b1;
        oam_we    = 1'b0;
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (!cpu_cs_n && !cpu_rw_n && (cpu_addr == DMA_REG_ADDR)) begin
                    trigger = 1'b1;
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            // An extra dummy cycle keeps reads on the same parity as real hardware
            ST_HALT:  state_d = odd_q ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                dma_cs_n = 1'b0;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                oam_we    = 1'b1;
                oam_addr  = idx_q;
                oam_wdata = mem_rdata;
                // End on the last index rather than on wrap, so idx never overflows mid-transfer
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CPU handshake decoded straight from the registered state
    assign cpu_rdy  = (state_q == ST_IDLE);
    assign dma_busy = ~cpu_rdy;

    nes_bus_mux u_bus_mux (
        .dma_sel    (dma_busy),
        .trig_block (trigger),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rw_n   (cpu_rw_n),
        .cpu_cs_n   (cpu_cs_n),
        .dma_addr   (dma_mem_addr(page_q, idx_q)),
        .dma_cs_n   (dma_cs_n),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw_n   (mem_rw_n),
        .mem_cs_n   (mem_cs_n)
    );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: RAM model, OAM capture and a transfer-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw_n;
    logic        cpu_cs_n;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rw_n;
    logic        mem_cs_n;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ram [0:65535];
    logic [7:0]  oam [0:255];
    logic        par;
    int          stall_cnt = 0;
    int          bad_wr = 0;
    logic [15:0] rd_q[$];
    logic [15:0] we_q[$];

    oam_dma_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw_n  (cpu_rw_n),
        .cpu_cs_n  (cpu_cs_n),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw_n  (mem_rw_n),
        .mem_cs_n  (mem_cs_n),
        .mem_rdata (mem_rdata),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .dma_busy  (dma_busy)
    );

    always #5 clk = ~clk;

    // RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (!mem_cs_n && mem_rw_n) mem_rdata <= ram[mem_addr];
    end

    // Cycle parity as seen from reset release: flips every clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) par <= 1'b0;
        else        par <= ~par;
    end

    // Mid-cycle observer: stall cycles, DMA reads, stray DMA writes, OAM strobes
    always @(negedge clk) begin
        if (rst_n && !cpu_rdy) stall_cnt++;
        if (dma_busy && !mem_cs_n && mem_rw_n) rd_q.push_back(mem_addr);
        if (dma_busy && !mem_cs_n && !mem_rw_n) bad_wr++;
        if (oam_we) begin
            we_q.push_back({oam_addr, oam_wdata});
            oam[oam_addr] = oam_wdata;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        cpu_cs_n  = 1'b1;
        cpu_rw_n  = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    task automatic wait_par(input logic want);
        sync();
        if (par !== want) sync();
    endtask

    // Full transfer from the current (ready) cycle; CPU inputs jitter randomly while held
    task automatic run_dma(input string tag, input logic [7:0] pg, output int stall);
        int s0, r0, w0, b0, exp_stall;
        logic p0;
        bit done;
        logic [7:0] ii;
        logic [15:0] e;
        cpu_cs_n  = 1'b0;
        cpu_rw_n  = 1'b0;
        cpu_addr  = 16'h4014;
        cpu_wdata = pg;
        #1;
        checks++;
        if (mem_cs_n !== 1'b1) begin
            failures++;
            $display("FAIL %s_trigger_not_forwarded mem_cs_n=%b expected=1", tag, mem_cs_n);
        end
        p0 = par;
        s0 = stall_cnt;
        r0 = rd_q.size();
        w0 = we_q.size();
        b0 = bad_wr;
        done = 1'b0;
        for (int c = 0; c < 700; c++) begin
            sync();
            if (cpu_rdy === 1'b1) begin
                done = 1'b1;
                break;
            end
            cpu_cs_n  = 1'($urandom);
            cpu_rw_n  = 1'($urandom);
            cpu_addr  = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
            cpu_wdata = 8'($urandom);
        end
        idle_bus();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_completion cpu_rdy never returned within 700 cycles", tag);
        end
        stall = stall_cnt - s0;
        exp_stall = p0 ? 513 : 514;
        checks++;
        if (stall != exp_stall) begin
            failures++;
            $display("FAIL %s_stall got=%0d expected=%0d", tag, stall, exp_stall);
        end
        checks++;
        if (rd_q.size() - r0 != 256) begin
            failures++;
            $display("FAIL %s_read_count got=%0d expected=256", tag, rd_q.size() - r0);
        end
        checks++;
        if (we_q.size() - w0 != 256) begin
            failures++;
            $display("FAIL %s_oam_we_count got=%0d expected=256", tag, we_q.size() - w0);
        end
        if (rd_q.size() >= r0 + 256) begin
            for (int i = 0; i < 256; i++) begin
                ii = i[7:0];
                checks++;
                if (rd_q[r0 + i] !== {pg, ii}) begin
                    failures++;
                    $display("FAIL %s_read_addr[%0d] got=%h expected=%h", tag, i, rd_q[r0 + i], {pg, ii});
                end
            end
        end
        if (we_q.size() >= w0 + 256) begin
            for (int i = 0; i < 256; i++) begin
                ii = i[7:0];
                e = we_q[w0 + i];
                checks++;
                if (e !== {ii, ram[{pg, ii}]}) begin
                    failures++;
                    $display("FAIL %s_oam_write[%0d] got=%h expected=%h", tag, i, e, {ii, ram[{pg, ii}]});
                end
            end
        end
        checks++;
        if (bad_wr != b0) begin
            failures++;
            $display("FAIL %s_dma_ram_write got=%0d expected=0", tag, bad_wr - b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        #3;
        cpu_cs_n = 1'b0;
        cpu_addr = 16'h1234;
        #1;
        checks++;
        if ({cpu_rdy, dma_busy, oam_we} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags got rdy/busy/we=%b expected=100", {cpu_rdy, dma_busy, oam_we});
        end
        checks++;
        if ({oam_addr, oam_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_oam_bus got=%h expected=0000", {oam_addr, oam_wdata});
        end
        checks++;
        if (mem_addr !== 16'h1234 || mem_cs_n !== 1'b0 || mem_rw_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_passthrough got addr=%h cs_n=%b rw_n=%b expected 1234/0/1", mem_addr, mem_cs_n, mem_rw_n);
        end
        idle_bus();
        repeat (3) sync();
        rst_n = 1'b1;
    endtask

    task automatic test_passthru();
        int w0;
        logic [15:0] a;
        w0 = we_q.size();
        sync();
        cpu_cs_n = 1'b0; cpu_rw_n = 1'b1; cpu_addr = 16'h0123;
        #1;
        checks++;
        if (mem_addr !== 16'h0123 || mem_rw_n !== 1'b1 || mem_cs_n !== 1'b0 || cpu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL pass_read got addr=%h rw_n=%b cs_n=%b rdy=%b", mem_addr, mem_rw_n, mem_cs_n, cpu_rdy);
        end
        sync();
        cpu_rw_n = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
        #1;
        checks++;
        if (mem_addr !== 16'h0200 || mem_wdata !== 8'h5A || mem_rw_n !== 1'b0 || mem_cs_n !== 1'b0) begin
            failures++;
            $display("FAIL pass_write got addr=%h data=%h rw_n=%b cs_n=%b", mem_addr, mem_wdata, mem_rw_n, mem_cs_n);
        end
        for (int k = 0; k < 24; k++) begin
            sync();
            a = 16'($urandom);
            if (a == 16'h4014) a = 16'h4015;
            cpu_addr = a; cpu_wdata = 8'($urandom);
            cpu_rw_n = 1'($urandom); cpu_cs_n = 1'($urandom);
            #1;
            checks++;
            if ({mem_addr, mem_wdata, mem_rw_n, mem_cs_n} !== {cpu_addr, cpu_wdata, cpu_rw_n, cpu_cs_n}) begin
                failures++;
                $display("FAIL pass_random[%0d] got=%h expected=%h", k,
                         {mem_addr, mem_wdata, mem_rw_n, mem_cs_n}, {cpu_addr, cpu_wdata, cpu_rw_n, cpu_cs_n});
            end
        end
        // Reading the DMA register, or an unselected write to it, must not start a transfer
        sync();
        cpu_cs_n = 1'b0; cpu_rw_n = 1'b1; cpu_addr = 16'h4014;
        #1;
        checks++;
        if (mem_cs_n !== 1'b0) begin
            failures++;
            $display("FAIL pass_read_4014 mem_cs_n=%b expected=0", mem_cs_n);
        end
        sync();
        cpu_cs_n = 1'b1; cpu_rw_n = 1'b0;
        sync();
        idle_bus();
        checks++;
        if (cpu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL pass_no_false_trigger cpu_rdy=%b expected=1", cpu_rdy);
        end
        sync();
        checks++;
        if (cpu_rdy !== 1'b1 || we_q.size() != w0) begin
            failures++;
            $display("FAIL pass_no_oam_we rdy=%b we_pulses=%0d expected 1/0", cpu_rdy, we_q.size() - w0);
        end
    endtask

    task automatic test_even_odd();
        int st;
        logic [7:0] ii;
        wait_par(1'b1);
        run_dma("even", 8'h02, st);
        checks++;
        if (st != 513) begin
            failures++;
            $display("FAIL even_stall_513 got=%0d expected=513", st);
        end
        for (int i = 0; i < 256; i++) begin
            ii = i[7:0];
            checks++;
            if (oam[i] !== (ii ^ 8'hA5)) begin
                failures++;
                $display("FAIL even_oam[%0d] got=%h expected=%h", i, oam[i], ii ^ 8'hA5);
            end
        end
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        wait_par(1'b0);
        run_dma("odd", 8'h02, st);
        checks++;
        if (st != 514) begin
            failures++;
            $display("FAIL odd_stall_514 got=%0d expected=514", st);
        end
        for (int i = 0; i < 256; i++) begin
            ii = i[7:0];
            checks++;
            if (oam[i] !== (ii ^ 8'hA5)) begin
                failures++;
                $display("FAIL odd_oam[%0d] got=%h expected=%h", i, oam[i], ii ^ 8'hA5);
            end
        end
    endtask

    task automatic test_top_page();
        int st, r0;
        repeat ($urandom_range(1, 4)) sync();
        run_dma("top", 8'hFF, st);
        checks++;
        if (we_q.size() == 0 || we_q[we_q.size() - 1][15:8] !== 8'hFF) begin
            failures++;
            $display("FAIL top_last_oam_addr got=%h expected=ff", (we_q.size() == 0) ? 8'h00 : we_q[we_q.size() - 1][15:8]);
        end
        r0 = rd_q.size();
        repeat (4) sync();
        checks++;
        if (rd_q.size() != r0 || cpu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL top_no_extra_read extra=%0d rdy=%b expected 0/1", rd_q.size() - r0, cpu_rdy);
        end
    endtask

    task automatic test_reset_mid();
        int w0, st;
        bit hit;
        logic [7:0] ii;
        sync();
        w0 = we_q.size();
        cpu_cs_n = 1'b0; cpu_rw_n = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h05;
        hit = 1'b0;
        for (int c = 0; c < 400; c++) begin
            sync();
            idle_bus();
            if (we_q.size() - w0 >= 100) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rstmid_reach_100 got=%0d pulses expected=100", we_q.size() - w0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rdy, dma_busy, oam_we} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_abort got rdy/busy/we=%b expected=100", {cpu_rdy, dma_busy, oam_we});
        end
        repeat (5) sync();
        checks++;
        if (we_q.size() - w0 != 100) begin
            failures++;
            $display("FAIL rstmid_no_more_we got=%0d expected=100", we_q.size() - w0);
        end
        for (int i = 0; i < 256; i++) begin
            ii = i[7:0];
            checks++;
            if (oam[i] !== ((i < 100) ? ram[{8'h05, ii}] : ram[{8'hFF, ii}])) begin
                failures++;
                $display("FAIL rstmid_oam[%0d] got=%h expected=%h", i, oam[i],
                         (i < 100) ? ram[{8'h05, ii}] : ram[{8'hFF, ii}]);
            end
        end
        rst_n = 1'b1;
        sync();
        run_dma("after_reset", 8'h05, st);
    endtask

    task automatic test_back_to_back();
        int st;
        repeat ($urandom_range(1, 3)) sync();
        run_dma("b2b_first", 8'($urandom_range(4, 254)), st);
        run_dma("b2b_second", 8'h03, st);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        test_reset();
        test_passthru();
        test_even_odd();
        test_top_page();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
